time_set_controller: RTL and testbench

- Button-driven front end that produces the time-set interface consumed by the clock block: `set_time`, `input_hour`, `input_min` and `input_sec`.
- On entry to edit mode it snapshots the running 24-hour time. It then edits the hour, minute and second fields in turn, with wrap-around and auto-repeat.
- Confirm commits the edited time with a single-cycle `set_time` pulse. Inactivity aborts the edit without committing.
- Sits between the board button inputs and the clock block inside the top-level driver.
- `clk` is the 1 Hz timekeeping clock.

---
 rtl/time_set_controller_if.sv | 32 +++
 rtl/time_set_controller.sv | 157 +++++++++++++++
 tb/tb_time_set_controller.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/time_set_controller_if.sv
// Time-set interface between the board button front end and the clock block.
// The controller drives the edited time and commit strobe; the driver side supplies buttons and running time.
interface time_set_controller_if;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic       btn_confirm;
  logic [7:0] current_24_hour;
  logic [7:0] current_24_min;
  logic [7:0] current_24_sec;
  logic       set_time;
  logic [7:0] input_hour;
  logic [7:0] input_min;
  logic [7:0] input_sec;
  logic       editing;
  logic [1:0] edit_field;
  logic       edit_timeout;

  modport master (
    output btn_mode, btn_up, btn_down, btn_confirm,
    output current_24_hour, current_24_min, current_24_sec,
    input  set_time, input_hour, input_min, input_sec,
    input  editing, edit_field, edit_timeout
  );

  modport slave (
    input  btn_mode, btn_up, btn_down, btn_confirm,
    input  current_24_hour, current_24_min, current_24_sec,
    output set_time, input_hour, input_min, input_sec,
    output editing, edit_field, edit_timeout
  );
endinterface

// File: rtl/time_set_controller.sv
// Button-driven time editor: snapshots the running time, edits hour/min/sec with
// wrap-around and auto-repeat, then commits with a one-cycle set_time strobe or aborts on inactivity.
module time_set_controller #(
  parameter int HOLD_CYCLES    = 2,
  parameter int REPEAT_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 30
) (
  input  logic                  clk,
  input  logic                  reset,
  time_set_controller_if.slave  tsc
);

  localparam int HW = $clog2(HOLD_CYCLES + REPEAT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_V    = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] RELOAD_AT = HW'(HOLD_CYCLES + REPEAT_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    EDIT_HOUR,
    EDIT_MIN,
    EDIT_SEC,
    COMMIT
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    btn_prev;
  logic [3:0]    btn_now;
  logic [3:0]    press;
  logic [7:0]    hour_q, hour_d;
  logic [7:0]    min_q, min_d;
  logic [7:0]    sec_q, sec_d;
  logic [HW-1:0] hold_q, hold_d, hold_inc;
  logic [TW-1:0] tout_q, tout_d, tout_inc;
  logic          timeout_q, timeout_d;
  logic          in_edit;
  logic          held_up, held_dn;
  logic          press_step, rep_hit, activity;

  function automatic logic [7:0] step_field(input logic [7:0] value, input logic up,
                                            input logic [7:0] top);
    if (up) return (value >= top) ? 8'd0 : value + 8'd1;
    else    return (value == 8'd0) ? top : value - 8'd1;
  endfunction

  // Button order in the vectors: {mode, up, down, confirm}
  assign btn_now = {tsc.btn_mode, tsc.btn_up, tsc.btn_down, tsc.btn_confirm};
  assign press   = btn_now & ~btn_prev;
  assign in_edit = (state_q == EDIT_HOUR) || (state_q == EDIT_MIN) || (state_q == EDIT_SEC);
  assign held_up = tsc.btn_up & ~tsc.btn_down;
  assign held_dn = tsc.btn_down & ~tsc.btn_up;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      btn_prev  <= '0;
      hour_q    <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      hold_q    <= '0;
      tout_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      btn_prev  <= btn_now;
      hour_q    <= hour_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      hold_q    <= hold_d;
      tout_q    <= tout_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    hold_d     = '0;
    tout_d     = '0;
    timeout_d  = 1'b0;
    press_step = 1'b0;
    rep_hit    = 1'b0;
    hold_inc   = hold_q + 1'b1;
    tout_inc   = tout_q + 1'b1;

    // Hold counter reloads to HOLD_V after each repeat step, so it never exceeds RELOAD_AT
    if (in_edit && (held_up || held_dn)) begin
      if ((held_up && press[2]) || (held_dn && press[1])) begin
        press_step = 1'b1;
      end else if (hold_inc == HOLD_V) begin
        rep_hit = 1'b1;
        hold_d  = hold_inc;
      end else if (hold_inc == RELOAD_AT) begin
        rep_hit = 1'b1;
        hold_d  = HOLD_V;
      end else begin
        hold_d = hold_inc;
      end
    end

    activity = (|press) | rep_hit;

    case (state_q)
      IDLE: begin
        if (press[3]) begin
          hour_d  = (tsc.current_24_hour > 8'd23) ? 8'd0 : tsc.current_24_hour;
          min_d   = (tsc.current_24_min  > 8'd59) ? 8'd0 : tsc.current_24_min;
          sec_d   = (tsc.current_24_sec  > 8'd59) ? 8'd0 : tsc.current_24_sec;
          state_d = EDIT_HOUR;
        end
      end
      EDIT_HOUR, EDIT_MIN, EDIT_SEC: begin
        if (press[0]) begin
          state_d = COMMIT;
        end else if (press[3]) begin
          state_d = (state_q == EDIT_HOUR) ? EDIT_MIN :
                    (state_q == EDIT_MIN)  ? EDIT_SEC : EDIT_HOUR;
        end else if (press_step || rep_hit) begin
          if (state_q == EDIT_HOUR)     hour_d = step_field(hour_q, held_up, 8'd23);
          else if (state_q == EDIT_MIN) min_d  = step_field(min_q,  held_up, 8'd59);
          else                          sec_d  = step_field(sec_q,  held_up, 8'd59);
        end
        if (!activity) begin
          if (tout_inc >= TIMEOUT_V) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
          end else begin
            tout_d = tout_inc;
          end
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tsc.edit_field = 2'd0;
    case (state_q)
      EDIT_HOUR: tsc.edit_field = 2'd1;
      EDIT_MIN:  tsc.edit_field = 2'd2;
      EDIT_SEC:  tsc.edit_field = 2'd3;
      default:   tsc.edit_field = 2'd0;
    endcase
  end

  assign tsc.set_time     = (state_q == COMMIT);
  assign tsc.editing      = in_edit;
  assign tsc.edit_timeout = timeout_q;
  assign tsc.input_hour   = hour_q;
  assign tsc.input_min    = min_q;
  assign tsc.input_sec    = sec_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Self-checking bench for time_set_controller: directed scenarios plus random button
// traffic, all compared against a behavioural model of the editing rules.
module tb_time_set_controller;

  localparam int HOLD = 2;
  localparam int REP  = 1;
  localparam int TO   = 30;

  logic clk = 1'b0;
  logic reset;

  time_set_controller_if tsc_bus();

  time_set_controller #(
    .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tsc(tsc_bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: m_state 0 idle, 1 hour, 2 min, 3 sec, 4 commit; m_hold counts edges since press
  int       m_state;
  int       m_fld[3];
  bit [3:0] m_prev;
  int       m_hold;
  int       m_idle;
  bit       m_to;
  int       cur_h, cur_m, cur_s;
  bit       rb_m, rb_u, rb_d, rb_c;
  bit       saw_set;

  task automatic checkOutput(input string tag, input logic [31:0] got, input int exp);
    vectors++;
    if (got !== 32'(exp)) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int wrapStep(input int v, input int d, input int m);
    return (v + d + m) % m;
  endfunction

  task automatic modelReset();
    m_state = 0;
    m_fld[0] = 0; m_fld[1] = 0; m_fld[2] = 0;
    m_prev = '0;
    m_hold = 0;
    m_idle = 0;
    m_to = 1'b0;
  endtask

  task automatic modelStep(input bit bm, input bit bu, input bit bd, input bit bc);
    bit pm, pu, pd, pc, edit, press_step, rep;
    int k;
    pm = bm && !m_prev[3];
    pu = bu && !m_prev[2];
    pd = bd && !m_prev[1];
    pc = bc && !m_prev[0];
    edit = (m_state >= 1) && (m_state <= 3);
    press_step = 1'b0;
    rep = 1'b0;
    k = 0;
    if (edit && (bu != bd)) begin
      if ((bu && pu) || (bd && pd)) press_step = 1'b1;
      else begin
        k = m_hold + 1;
        rep = (k >= HOLD) && (((k - HOLD) % REP) == 0);
      end
    end
    m_to = 1'b0;
    case (m_state)
      0: if (pm) begin
        m_fld[0] = (cur_h > 23) ? 0 : cur_h;
        m_fld[1] = (cur_m > 59) ? 0 : cur_m;
        m_fld[2] = (cur_s > 59) ? 0 : cur_s;
        m_state = 1;
        m_idle = 0;
      end
      4: m_state = 0;
      default: begin
        if (pc) m_state = 4;
        else if (pm) m_state = (m_state == 3) ? 1 : m_state + 1;
        else if (press_step || rep)
          m_fld[m_state-1] = wrapStep(m_fld[m_state-1], bu ? 1 : -1, (m_state == 1) ? 24 : 60);
        if (pm || pu || pd || pc || rep) m_idle = 0;
        else begin
          m_idle++;
          if (m_idle >= TO) begin
            m_state = 0;
            m_to = 1'b1;
            m_idle = 0;
          end
        end
      end
    endcase
    m_hold = k;
    m_prev = {bm, bu, bd, bc};
  endtask

  task automatic compareModel();
    int ed;
    ed = (m_state >= 1 && m_state <= 3) ? 1 : 0;
    checkOutput("set_time",     tsc_bus.set_time,     (m_state == 4) ? 1 : 0);
    checkOutput("editing",      tsc_bus.editing,      ed);
    checkOutput("edit_field",   tsc_bus.edit_field,   ed ? m_state : 0);
    checkOutput("edit_timeout", tsc_bus.edit_timeout, m_to ? 1 : 0);
    checkOutput("input_hour",   tsc_bus.input_hour,   m_fld[0]);
    checkOutput("input_min",    tsc_bus.input_min,    m_fld[1]);
    checkOutput("input_sec",    tsc_bus.input_sec,    m_fld[2]);
  endtask

  task automatic setTime(input int h, input int m, input int s);
    cur_h = h; cur_m = m; cur_s = s;
    tsc_bus.current_24_hour = 8'(h);
    tsc_bus.current_24_min  = 8'(m);
    tsc_bus.current_24_sec  = 8'(s);
  endtask

  // Drive one cycle of buttons, advance the model, then compare on the following falling edge
  task automatic applyStimulus(input bit bm, input bit bu, input bit bd, input bit bc);
    tsc_bus.btn_mode    = bm;
    tsc_bus.btn_up      = bu;
    tsc_bus.btn_down    = bd;
    tsc_bus.btn_confirm = bc;
    modelStep(bm, bu, bd, bc);
    @(negedge clk);
    compareModel();
  endtask

  task automatic doReset();
    #2;
    reset = 1'b0;
    tsc_bus.btn_mode = 1'b0; tsc_bus.btn_up = 1'b0;
    tsc_bus.btn_down = 1'b0; tsc_bus.btn_confirm = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_set_time", tsc_bus.set_time,     0);
    checkOutput("rst_editing",  tsc_bus.editing,      0);
    checkOutput("rst_field",    tsc_bus.edit_field,   0);
    checkOutput("rst_timeout",  tsc_bus.edit_timeout, 0);
    checkOutput("rst_hour",     tsc_bus.input_hour,   0);
    checkOutput("rst_min",      tsc_bus.input_min,    0);
    checkOutput("rst_sec",      tsc_bus.input_sec,    0);
    @(negedge clk);
    compareModel();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    tsc_bus.btn_mode = 1'b0; tsc_bus.btn_up = 1'b0;
    tsc_bus.btn_down = 1'b0; tsc_bus.btn_confirm = 1'b0;
    setTime(0, 0, 0);
    modelReset();
    @(negedge clk);
    compareModel();
    @(negedge clk);
    reset = 1'b1;

    // Basic edit 13:45:07 -> 15:44:07
    setTime(13, 45, 7);
    applyStimulus(1, 0, 0, 0);
    checkOutput("basic_field", tsc_bus.edit_field, 1);
    checkOutput("basic_load",  tsc_bus.input_hour, 13);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0); applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0); applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0); applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0); applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("basic_set",  tsc_bus.set_time,   1);
    checkOutput("basic_hour", tsc_bus.input_hour, 15);
    checkOutput("basic_min",  tsc_bus.input_min,  44);
    checkOutput("basic_sec",  tsc_bus.input_sec,  7);
    applyStimulus(0, 0, 0, 0);
    checkOutput("basic_set_end", tsc_bus.set_time, 0);
    checkOutput("basic_idle",    tsc_bus.editing,  0);

    // Wrap-around 23:00:00 -> 00:00:59
    setTime(23, 0, 0);
    applyStimulus(1, 0, 0, 0); applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0); applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0); applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0); applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0); applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("wrap_set",  tsc_bus.set_time,   1);
    checkOutput("wrap_hour", tsc_bus.input_hour, 0);
    checkOutput("wrap_min",  tsc_bus.input_min,  0);
    checkOutput("wrap_sec",  tsc_bus.input_sec,  59);
    applyStimulus(0, 0, 0, 0);

    // Auto-repeat: up held six edges on minute 10 -> 15
    setTime(0, 10, 0);
    applyStimulus(1, 0, 0, 0); applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0); applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("repeat_min", tsc_bus.input_min, 15);
    applyStimulus(0, 0, 0, 1); applyStimulus(0, 0, 0, 0);

    // Timeout after 30 idle edges, no commit, shadow kept
    setTime(8, 30, 15);
    applyStimulus(1, 0, 0, 0);
    saw_set = 1'b0;
    for (int i = 0; i < TO; i++) begin
      applyStimulus(0, 0, 0, 0);
      if (tsc_bus.set_time) saw_set = 1'b1;
    end
    checkOutput("to_pulse",   tsc_bus.edit_timeout, 1);
    checkOutput("to_editing", tsc_bus.editing,      0);
    checkOutput("to_noset",   saw_set,              0);
    checkOutput("to_hour",    tsc_bus.input_hour,   8);
    checkOutput("to_min",     tsc_bus.input_min,    30);
    checkOutput("to_sec",     tsc_bus.input_sec,    15);
    applyStimulus(0, 0, 0, 0);
    checkOutput("to_pulse_end", tsc_bus.edit_timeout, 0);

    // Simultaneous up+down, then confirm+up
    setTime(5, 0, 0);
    applyStimulus(1, 0, 0, 0); applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0);
    checkOutput("updown_hour", tsc_bus.input_hour, 5);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1);
    checkOutput("confup_set",  tsc_bus.set_time,   1);
    checkOutput("confup_hour", tsc_bus.input_hour, 5);
    applyStimulus(0, 0, 0, 0);
    checkOutput("confup_set_end", tsc_bus.set_time, 0);

    // Reset in the middle of an edit
    setTime(12, 0, 0);
    applyStimulus(1, 0, 0, 0); applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    doReset();

    // Random button traffic with quiet stretches and occasional out-of-range time
    rb_m = 0; rb_u = 0; rb_d = 0; rb_c = 0;
    for (int seg = 0; seg < 80; seg++) begin
      bit quiet;
      int len;
      quiet = ($urandom_range(0, 4) == 0);
      len = $urandom_range(10, 45);
      for (int c = 0; c < len; c++) begin
        if (quiet) begin
          rb_m = 0; rb_u = 0; rb_d = 0; rb_c = 0;
        end else begin
          if ($urandom_range(0, 5) == 0)  rb_m = ~rb_m;
          if ($urandom_range(0, 2) == 0)  rb_u = ~rb_u;
          if ($urandom_range(0, 2) == 0)  rb_d = ~rb_d;
          if ($urandom_range(0, 11) == 0) rb_c = ~rb_c;
        end
        if ($urandom_range(0, 7) == 0)
          setTime($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
        applyStimulus(rb_m, rb_u, rb_d, rb_c);
      end
      if ($urandom_range(0, 15) == 0) begin
        doReset();
        rb_m = 0; rb_u = 0; rb_d = 0; rb_c = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
